// File: rtl/barrel_shift_pkg.sv
// Shared types for the 8-bit rotating barrel shifter and its command buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package barrel_shift_pkg;

  localparam int SHIFT_WIDTH = 8;
  localparam int SHIFT_AMT_W = 3;

  typedef enum logic {
    ROTATE_LEFT  = 1'b0,
    ROTATE_RIGHT = 1'b1
  } rot_dir_t;

  typedef struct packed {
    rot_dir_t                 dir;
    logic [SHIFT_AMT_W-1:0]   amt;
    logic [SHIFT_WIDTH-1:0]   data;
  } shift_cmd_t;

endpackage : barrel_shift_pkg

// File: rtl/barrel_shift_cmd_fifo.sv
// Circular command FIFO in front of the barrel shifter; head shown on shifter-named ports.
// Latency: push into empty queue is visible the cycle after the push edge (no fall-through).
// Backpressure: in_ready = !full (state only); pushes while full are dropped and flagged sticky.
module barrel_shift_cmd_fifo
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int DEPTH = 4,
  parameter int AMT_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  rot_dir_t         in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic [AMT_W-1:0] amt,
  output rot_dir_t         dir_lr,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  // Entry layout is {dir, amt, data}, the same order as shift_cmd_t, but sized
  // from the parameters so non-default widths still work.
  localparam int ENT_W = WIDTH + AMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  // Flush suppresses both transfers so nothing lands in storage on that edge.
  assign push  = in_valid && !full && !flush;
  assign pop   = !empty && out_ready && !flush;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
    // Set takes priority over clear; flush leaves the flag alone.
    ovf_d = ovf_q;
    if (in_valid && full) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write; contents need no reset because out_valid gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_dir, in_amt, in_data};
  end

  // Show-ahead head; forced to a benign zero/left command when empty.
  always_comb begin
    head   = mem_q[rd_ptr_q];
    data   = '0;
    amt    = '0;
    dir_lr = ROTATE_LEFT;
    if (!empty) begin
      data   = head[WIDTH-1:0];
      amt    = head[WIDTH+AMT_W-1:WIDTH];
      dir_lr = rot_dir_t'(head[ENT_W-1]);
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule : barrel_shift_cmd_fifo

// File: tb/tb_barrel_shift_cmd_fifo.sv
// Self-checking bench for barrel_shift_cmd_fifo: directed vector table, hand sequences, random vs queue model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: producer/consumer duty cycles are varied to reach full and empty often.
module tb_barrel_shift_cmd_fifo;
  import barrel_shift_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready, ovf_clr;
  logic       in_ready, out_valid, overflow;
  logic [7:0] in_data, data;
  logic [2:0] in_amt, amt;
  rot_dir_t   in_dir, dir_lr;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  barrel_shift_cmd_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .data(data), .amt(amt), .dir_lr(dir_lr),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] a;
    rot_dir_t   dir;
    logic       ordy, fl, clr;
    logic       e_ir, e_ov;
    logic [7:0] e_d;
    logic [2:0] e_a;
    rot_dir_t   e_dir;
    logic [2:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [2:0] a, input rot_dir_t dir,
                     input logic ordy, input logic fl, input logic clr,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_d, input logic [2:0] e_a,
                     input rot_dir_t e_dir, input logic [2:0] e_cnt, input logic e_ovf);
    vec_t t;
    t.v = v; t.d = d; t.a = a; t.dir = dir; t.ordy = ordy; t.fl = fl; t.clr = clr;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_d = e_d; t.e_a = e_a; t.e_dir = e_dir;
    t.e_cnt = e_cnt; t.e_ovf = e_ovf;
    vecs.push_back(t);
  endtask

  // Numbered wrap-test commands: data 0x10+n, amount n mod 8, odd n rotate right.
  function automatic logic [7:0] nd(input int n);
    return 8'(8'h10 + n);
  endfunction
  function automatic logic [2:0] na(input int n);
    return 3'(n % 8);
  endfunction
  function automatic rot_dir_t ndir(input int n);
    return rot_dir_t'(1'(n % 2));
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] a);
    logic [15:0] t;
    t = {d, d} << a;
    return t[15:8];
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input rot_dir_t dir,
                       input logic ordy, input logic fl, input logic clr);
    in_valid = v; in_data = d; in_amt = a; in_dir = dir;
    out_ready = ordy; flush = fl; ovf_clr = clr;
  endtask

  task automatic chk_all(input string tag, input logic e_ir, input logic e_ov, input logic [7:0] e_d,
                         input logic [2:0] e_a, input rot_dir_t e_dir, input logic [2:0] e_cnt,
                         input logic e_ovf);
    chk({tag, ".in_ready"},  in_ready,  e_ir);
    chk({tag, ".out_valid"}, out_valid, e_ov);
    chk({tag, ".data"},      data,      e_d);
    chk({tag, ".amt"},       amt,       e_a);
    chk({tag, ".dir_lr"},    dir_lr,    e_dir);
    chk({tag, ".count"},     count,     e_cnt);
    chk({tag, ".overflow"},  overflow,  e_ovf);
  endtask

  localparam rot_dir_t L = ROTATE_LEFT;
  localparam rot_dir_t R = ROTATE_RIGHT;

  // Reference model state for the random phase.
  logic [11:0] mq[$];
  logic        m_ovf;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    // ---------------- directed vector table ----------------
    // single command, then drain
    add(1, 8'h01, 3, L, 0, 0, 0,   1, 1, 8'h01, 3, L, 1, 0);
    add(0, 8'h00, 0, L, 1, 0, 0,   1, 0, 8'h00, 0, L, 0, 0);
    // ordered burst to full
    add(1, 8'h01, 0, L, 0, 0, 0,   1, 1, 8'h01, 0, L, 1, 0);
    add(1, 8'h01, 1, L, 0, 0, 0,   1, 1, 8'h01, 0, L, 2, 0);
    add(1, 8'h01, 2, L, 0, 0, 0,   1, 1, 8'h01, 0, L, 3, 0);
    add(1, 8'h01, 3, L, 0, 0, 0,   0, 1, 8'h01, 0, L, 4, 0);
    // push while full: dropped, overflow set; then clear
    add(1, 8'hFF, 7, R, 0, 0, 0,   0, 1, 8'h01, 0, L, 4, 1);
    add(0, 8'h00, 0, L, 0, 0, 1,   0, 1, 8'h01, 0, L, 4, 0);
    // push+pop while full: pop only, push refused (and flagged)
    add(1, 8'h55, 5, R, 1, 0, 0,   1, 1, 8'h01, 1, L, 3, 1);
    add(0, 8'h00, 0, L, 0, 0, 1,   1, 1, 8'h01, 1, L, 3, 0);
    // drain in order
    add(0, 8'h00, 0, L, 1, 0, 0,   1, 1, 8'h01, 2, L, 2, 0);
    add(0, 8'h00, 0, L, 1, 0, 0,   1, 1, 8'h01, 3, L, 1, 0);
    add(0, 8'h00, 0, L, 1, 0, 0,   1, 0, 8'h00, 0, L, 0, 0);
    // fill to two, then ten cycles of simultaneous push and pop across the wrap
    add(1, nd(0), na(0), ndir(0), 0, 0, 0,   1, 1, nd(0), na(0), ndir(0), 1, 0);
    add(1, nd(1), na(1), ndir(1), 0, 0, 0,   1, 1, nd(0), na(0), ndir(0), 2, 0);
    for (int j = 0; j < 10; j++)
      add(1, nd(j + 2), na(j + 2), ndir(j + 2), 1, 0, 0,
          1, 1, nd(j + 1), na(j + 1), ndir(j + 1), 2, 0);
    // fill to four, overflow with simultaneous clear (set wins), pop to three
    add(1, nd(12), na(12), ndir(12), 0, 0, 0,   1, 1, nd(10), na(10), ndir(10), 3, 0);
    add(1, nd(13), na(13), ndir(13), 0, 0, 0,   0, 1, nd(10), na(10), ndir(10), 4, 0);
    add(1, 8'hFF, 7, R, 0, 0, 1,                0, 1, nd(10), na(10), ndir(10), 4, 1);
    add(0, 8'h00, 0, L, 1, 0, 0,                1, 1, nd(11), na(11), ndir(11), 3, 1);
    // flush with push and pop requested: queue empties, overflow retained
    add(1, 8'h77, 1, R, 1, 1, 0,                1, 0, 8'h00, 0, L, 0, 1);
    add(0, 8'h00, 0, L, 0, 0, 1,                1, 0, 8'h00, 0, L, 0, 0);
    add(1, nd(14), na(14), ndir(14), 0, 0, 0,   1, 1, nd(14), na(14), ndir(14), 1, 0);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(0, 8'h00, 0, L, 0, 0, 0);
    #12;
    chk_all("reset_hold", 1, 0, 8'h00, 0, L, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("reset_release", 1, 0, 8'h00, 0, L, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_d, vecs[i].e_a,
              vecs[i].e_dir, vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // ---------------- reset mid-burst ----------------
    drive(1, 8'hA5, 2, R, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 8'h5A, 6, R, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 8'h00, 0, L, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("midreset_hold", 1, 0, 8'h00, 0, L, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("midreset_release", 1, 0, 8'h00, 0, L, 0, 0);

    // ---------------- downstream shifter view ----------------
    drive(1, 8'h01, 3, L, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 8'h00, 0, L, 0, 0, 0);
    chk("shifter_out", (dir_lr == L) ? rotl8(data, amt) : 8'h00, 8'h08);
    chk("shifter_vld", out_valid, 1'b1);

    // ---------------- random vs queue model ----------------
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 900; c++) begin
      int ph;
      logic r_v, r_or, r_fl, r_clr, m_full;
      logic [7:0] r_d;
      logic [2:0] r_a;
      rot_dir_t r_dir;
      logic [11:0] h;
      string tag;
      tag = $sformatf("rnd%0d", c);
      h = (mq.size() > 0) ? mq[0] : 12'h000;
      chk_all(tag, mq.size() < DEPTH, mq.size() > 0, h[7:0], h[10:8], rot_dir_t'(h[11]),
              3'(mq.size()), m_ovf);
      ph = (c / 100) % 3;
      r_v   = ($urandom_range(99) < (ph == 0 ? 90 : ph == 1 ? 50 : 25));
      r_or  = ($urandom_range(99) < (ph == 0 ? 25 : ph == 1 ? 50 : 90));
      r_fl  = ($urandom_range(31) == 0);
      r_clr = ($urandom_range(7) == 0);
      r_d   = 8'($urandom);
      r_a   = 3'($urandom);
      r_dir = rot_dir_t'(1'($urandom));
      drive(r_v, r_d, r_a, r_dir, r_or, r_fl, r_clr);
      m_full = (mq.size() == DEPTH);
      if (r_v && m_full) m_ovf = 1'b1;
      else if (r_clr)    m_ovf = 1'b0;
      if (r_fl) begin
        mq.delete();
      end else begin
        if (r_or && mq.size() > 0) void'(mq.pop_front());
        if (r_v && !m_full) mq.push_back({r_dir, r_a, r_d});
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_barrel_shift_cmd_fifo

// File: doc/barrel_shift_cmd_fifo.md
Name: barrel_shift_cmd_fifo

Overview:
- Command buffer directly upstream of the 8-bit rotating barrel shifter.
- Accepts rotate commands {data, amt, direction} over a valid/ready handshake and queues them in a small circular FIFO.
- Presents the head command on ports named exactly as the shifter inputs (data, amt, dir_lr), so the shifter connects by name.
- Lets a bursty producer drive the combinational shifter at one command per cycle, with back-pressure, an occupancy count and an overflow flag.

Parameters:
- WIDTH, 8: data width; must equal the shifter data width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- AMT_W, $clog2(WIDTH) = 3: shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue contents.
- in_valid  in  1  producer has a command.
- in_ready  out  1  FIFO can accept a command; equals !full.
- in_data  in  WIDTH  operand to rotate.
- in_amt  in  AMT_W  rotate amount.
- in_dir  in  1  ROTATE_LEFT or ROTATE_RIGHT.
- out_valid  out  1  head command valid; equals !empty.
- out_ready  in  1  consumer takes the head this cycle.
- data  out  WIDTH  head operand, to shifter.
- amt  out  AMT_W  head amount, to shifter.
- dir_lr  out  1  head direction, to shifter.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when in_valid is high while full.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous): pointers = 0, count = 0, overflow = 0, storage contents don't-care. Observable outputs during and after reset: in_ready = 1, out_valid = 0, data = 0, amt = 0, dir_lr = ROTATE_LEFT. Reset mid-burst discards all queued entries.
- Storage: DEPTH entries of {dir, amt, data}, WIDTH+AMT_W+1 bits each. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: when in_valid && in_ready at a rising edge, write the entry at wr_ptr, then increment wr_ptr.
- Pop: when out_valid && out_ready at a rising edge, increment rd_ptr.
- Show-ahead: data, amt and dir_lr are driven combinationally from the entry at rd_ptr whenever out_valid = 1. When out_valid = 0 they are forced to 0 / 0 / ROTATE_LEFT, so the shifter sees a defined value.
- Latency: a push into an empty FIFO appears on the outputs, with out_valid = 1, in the cycle after the push edge. No same-cycle fall-through.
- in_ready depends only on state (!full). It never depends combinationally on out_ready.
- Push and pop in the same cycle:
  - Not empty and not full: both happen, count unchanged.
  - Full: the pop happens and the push is refused (in_ready = 0); count drops by 1.
  - Empty: only the push happens.
- count: +1 on push only, -1 on pop only, unchanged otherwise. Never exceeds DEPTH and never underflows.
- overflow:
  - Set on any edge where in_valid = 1 and full = 1. The command is dropped, not written.
  - Stays set until an edge where ovf_clr = 1.
  - If set and clear occur in the same cycle, set wins.
- flush: at the edge, pointers and count go to 0 and any push or pop in that cycle is ignored. overflow is unaffected. out_valid is 0 in the next cycle.
- No arithmetic on the payload: amt and data pass through bit-exact. Amount wrap (mod WIDTH) is the shifter's responsibility.

Decomposition:
- Shared package barrel_shift_pkg holds:
  - typedef enum logic {ROTATE_LEFT = 1'b0, ROTATE_RIGHT = 1'b1} rot_dir_t.
  - Constants SHIFT_WIDTH = 8 and SHIFT_AMT_W = 3.
  - Packed struct shift_cmd_t {rot_dir_t dir; logic [2:0] amt; logic [7:0] data}.
- The shifter and this FIFO both import barrel_shift_pkg.
- No sub-module is required: storage, pointers and flags stay in one module.

Test Plan:
- Reset: hold rst_n = 0 mid-stream -> in_ready = 1, out_valid = 0, data = 0x00, amt = 0, dir_lr = ROTATE_LEFT, count = 0, overflow = 0.
- Single command: push {0x01, 3, ROTATE_LEFT} into an empty FIFO -> next cycle out_valid = 1, data = 0x01, amt = 3, dir_lr = ROTATE_LEFT, count = 1. Downstream shifter output = 0x08.
- Ordered burst: with out_ready = 0, push four commands data = 0x01, amt = 0..3 -> count = 4, in_ready = 0. Then hold out_ready = 1 -> heads appear in order amt 0,1,2,3, one per cycle, then out_valid = 0.
- Overflow: with the FIFO full, assert in_valid with 0xFF -> overflow = 1, count stays 4, and 0xFF never appears at the output. Pulse ovf_clr -> overflow = 0.
- Simultaneous events and wrap:
  - At count = 2, push and pop together for 10 cycles -> count stays 2 and the pointers wrap past entry 3 with correct order.
  - At count = 4, assert push and pop together -> count = 3 and the push is refused.
- Flush: at count = 3 with overflow set, assert flush together with in_valid -> next cycle count = 0, out_valid = 0, overflow still 1.
